// File: rtl/xor_logic_serial.sv
// xor_logic_serial: multi-cycle bitwise logic unit (XOR/AND/OR/XNOR).
// The operands are processed SLICE bits per clock, LSB slice first. The result
// and the flags are returned over a valid/ready handshake.
//
// Ports:
//   clk, rst_n          clock; synchronous active-low reset
//   in_valid, in_ready  operand handshake (in_ready high only in IDLE)
//   op                  00 XOR, 01 AND, 10 OR, 11 XNOR
//   in1, in2            WIDTH-bit operands
//   out_valid, out_ready result handshake
//   out                 WIDTH-bit result, held until the next result completes
//   ZF, SF, OF_FLAG     zero, sign, overflow (overflow is always 0)
module xor_logic_serial #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned SLICE = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             ZF,
    output logic             SF,
    output logic             OF_FLAG
);

    localparam int unsigned NSLICE = WIDTH / SLICE;
    localparam int unsigned KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [KW-1:0]    k;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] acc;
    logic             zero_q;

    logic [SLICE-1:0] a_s_c;
    logic [SLICE-1:0] b_s_c;
    logic [SLICE-1:0] slice_c;
    logic [WIDTH-1:0] acc_c;
    logic             last_c;
    logic             accept_c;
    logic             step_c;
    logic             finish_c;
    logic             take_c;

    // Current slice of both operands, the op applied to it, and the accumulator
    // with that slice merged in (used directly for the final result load).
    always_comb begin
        a_s_c   = SLICE'(a_q >> (32'(k) * SLICE));
        b_s_c   = SLICE'(b_q >> (32'(k) * SLICE));
        slice_c = '0;
        case (op_q)
            2'b00:   slice_c = a_s_c ^ b_s_c;
            2'b01:   slice_c = a_s_c & b_s_c;
            2'b10:   slice_c = a_s_c | b_s_c;
            default: slice_c = ~(a_s_c ^ b_s_c);
        endcase
        acc_c  = acc | (WIDTH'(slice_c) << (32'(k) * SLICE));
        last_c = (k == KW'(NSLICE - 1));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and datapath strobes.
    always_comb begin
        state_next = state;
        accept_c   = 1'b0;
        step_c     = 1'b0;
        finish_c   = 1'b0;
        take_c     = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    accept_c   = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                step_c = 1'b1;
                if (last_c) begin
                    finish_c   = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    take_c     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, slice iteration and result/flag registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_ready  <= 1'b1;
            k         <= '0;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            acc       <= '0;
            zero_q    <= 1'b1;
            out_valid <= 1'b0;
            out       <= '0;
            ZF        <= 1'b0;
            SF        <= 1'b0;
            OF_FLAG   <= 1'b0;
        end else begin
            in_ready <= (state_next == IDLE);
            OF_FLAG  <= 1'b0;
            if (accept_c) begin
                op_q   <= op;
                a_q    <= in1;
                b_q    <= in2;
                k      <= '0;
                acc    <= '0;
                zero_q <= 1'b1;
            end
            if (step_c) begin
                acc    <= acc_c;
                zero_q <= zero_q & (slice_c == '0);
                k      <= last_c ? '0 : k + KW'(1);
            end
            // Result and flags update only as a complete word.
            if (finish_c) begin
                out       <= acc_c;
                ZF        <= zero_q & (slice_c == '0);
                SF        <= acc_c[WIDTH-1];
                out_valid <= 1'b1;
            end else if (take_c) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_xor_logic_serial.sv
// Bench for xor_logic_serial: a sliced instance (64/16) driven by directed and
// random transactions, and a single-slice instance (64/64) streaming with
// in_valid and out_ready tied high. Expected results are queued at acceptance
// and compared by independent output monitors.
module tb_xor_logic_serial;

    localparam int unsigned W    = 64;
    localparam int unsigned NS_A = 4;
    localparam int unsigned NS_B = 1;

    typedef struct {
        logic [W-1:0] r;
        logic         zf;
        logic         sf;
        int           cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int errors = 0;
    int checks = 0;

    // Instance A: 64-bit, 16-bit slices
    logic         rst_n, in_valid, in_ready, out_valid, out_ready;
    logic [1:0]   op;
    logic [W-1:0] in1, in2, out;
    logic         zf, sf, of_flag;

    // Instance B: 64-bit, single slice, streaming
    logic         rst2_n, in_valid2, in_ready2, out_valid2, out_ready2;
    logic [1:0]   op2;
    logic [W-1:0] in1b, in2b, outb;
    logic         zf2, sf2, of2;

    xor_logic_serial #(.WIDTH(64), .SLICE(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .in1(in1), .in2(in2), .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .ZF(zf), .SF(sf), .OF_FLAG(of_flag)
    );

    xor_logic_serial #(.WIDTH(64), .SLICE(64)) dut_b (
        .clk(clk), .rst_n(rst2_n), .in_valid(in_valid2), .in_ready(in_ready2),
        .op(op2), .in1(in1b), .in2(in2b), .out_valid(out_valid2), .out_ready(out_ready2),
        .out(outb), .ZF(zf2), .SF(sf2), .OF_FLAG(of2)
    );

    exp_t qa[$];
    exp_t qb[$];
    logic [W-1:0] last_out_a = '0;

    // Whole-word reference: the ops are purely bitwise, so no slicing is needed.
    function automatic logic [W-1:0] model(input logic [1:0] o, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        case (o)
            2'b00:   return a ^ b;
            2'b01:   return a & b;
            2'b10:   return a | b;
            default: return ~(a ^ b);
        endcase
    endfunction

    function automatic exp_t mk_exp(input logic [1:0] o, input logic [W-1:0] a,
                                    input logic [W-1:0] b, input int c);
        exp_t e;
        e.r   = model(o, a, b);
        e.zf  = (e.r == '0);
        e.sf  = e.r[W-1];
        e.cyc = c;
        return e;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks = checks + 1;
        if (act !== req) begin
            errors = errors + 1;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Scoreboard push at acceptance; a reset discards anything in flight.
    always @(negedge clk) begin
        if (!rst_n) qa.delete();
        else if (in_valid && in_ready) qa.push_back(mk_exp(op, in1, in2, cyc));
    end

    always @(negedge clk) begin
        if (!rst2_n) qb.delete();
        else if (in_valid2 && in_ready2) qb.push_back(mk_exp(op2, in1b, in2b, cyc));
    end

    // Output monitor A: latency at valid rise, values at handshake.
    logic prev_va = 1'b0;
    always @(negedge clk) begin
        if (out_valid && !prev_va) begin
            chk("a_result_expected", W'(qa.size() != 0), W'(1));
            if (qa.size() != 0) chk("a_latency", W'(cyc - qa[0].cyc), W'(NS_A + 1));
        end
        if (out_valid && out_ready) begin
            if (qa.size() != 0) begin
                exp_t e;
                e = qa.pop_front();
                chk("a_out", out, e.r);
                chk("a_zf", W'(zf), W'(e.zf));
                chk("a_sf", W'(sf), W'(e.sf));
                chk("a_of", W'(of_flag), W'(0));
                last_out_a = out;
            end
        end
        prev_va = out_valid;
    end

    // Output monitor B: latency, 3-clock result spacing, values.
    logic prev_vb = 1'b0;
    int   last_rise_b = -1;
    always @(negedge clk) begin
        if (!rst2_n) last_rise_b = -1;
        if (out_valid2 && !prev_vb) begin
            chk("b_result_expected", W'(qb.size() != 0), W'(1));
            if (qb.size() != 0) chk("b_latency", W'(cyc - qb[0].cyc), W'(NS_B + 1));
            if (last_rise_b >= 0) chk("b_spacing", W'(cyc - last_rise_b), W'(3));
            last_rise_b = cyc;
        end
        if (out_valid2 && out_ready2 && qb.size() != 0) begin
            exp_t e;
            e = qb.pop_front();
            chk("b_out", outb, e.r);
            chk("b_zf", W'(zf2), W'(e.zf));
            chk("b_sf", W'(sf2), W'(e.sf));
            chk("b_of", W'(of2), W'(0));
        end
        prev_vb = out_valid2;
    end

    // Instance B operands change every clock.
    assign in_valid2  = 1'b1;
    assign out_ready2 = 1'b1;
    always @(posedge clk) begin
        #1;
        op2  = 2'($urandom_range(0, 3));
        in1b = {$urandom, $urandom};
        in2b = ($urandom_range(0, 4) == 0) ? in1b : {$urandom, $urandom};
    end

    task automatic send(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        int   n;
        logic took;
        n    = 0;
        took = 1'b0;
        @(posedge clk); #1;
        op = o; in1 = a; in2 = b; in_valid = 1'b1;
        while (!took && n < 100) begin
            @(negedge clk);
            took = in_ready;
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        chk("accept_timeout", W'(took), W'(1));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((qa.size() != 0 || out_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", W'(n < 200), W'(1));
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        logic [W-1:0] snap;
        logic         snap_zf, snap_sf;
        logic [W-1:0] a, b;
        int           n;

        rst_n = 1'b0; rst2_n = 1'b0;
        in_valid = 1'b0; op = 2'b00; in1 = '0; in2 = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", W'(out_valid), W'(0));
        chk("rst_out", out, W'(0));
        chk("rst_in_ready", W'(in_ready), W'(1));
        chk("rst_flags", W'({zf, sf, of_flag}), W'(0));
        @(posedge clk); #1;
        rst_n = 1'b1; rst2_n = 1'b1;

        // Directed cases, each also compared to a hand-computed constant.
        send(2'b00, 64'b100110, 64'b110001);
        wait_idle();
        chk("tp_xor", last_out_a, 64'h17);
        send(2'b00, -64'sd45, -64'sd45);
        wait_idle();
        chk("tp_xor_zero", last_out_a, 64'h0);
        chk("tp_xor_zf", W'(zf), W'(1));
        send(2'b11, -64'sd45, -64'sd45);
        wait_idle();
        chk("tp_xnor", last_out_a, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("tp_xnor_sf", W'(sf), W'(1));
        send(2'b01, -64'sd33, -64'sd34);
        wait_idle();
        chk("tp_and", last_out_a, 64'hFFFF_FFFF_FFFF_FFDE);
        send(2'b10, -64'sd45, 64'b010101);
        wait_idle();
        chk("tp_or", last_out_a, 64'hFFFF_FFFF_FFFF_FFD7);

        // Backpressure: result held while a new request waits at the input.
        out_ready = 1'b0;
        send(2'b00, 64'h0123_4567_89AB_CDEF, 64'hFFFF_0000_FFFF_0000);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("bp_valid_rise", W'(out_valid), W'(1));
        snap = out; snap_zf = zf; snap_sf = sf;
        @(posedge clk); #1;
        op = 2'b01; in1 = 64'hFF00_FF00_FF00_FF00; in2 = 64'h0FF0_0FF0_0FF0_0FF0;
        in_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("bp_out_stable", out, snap);
            chk("bp_flags_stable", W'({zf, sf}), W'({snap_zf, snap_sf}));
            chk("bp_valid_held", W'(out_valid), W'(1));
            chk("bp_in_ready_low", W'(in_ready), W'(0));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            if (in_ready) break;
            n++;
        end
        chk("bp_reaccept", W'(in_ready), W'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_idle();
        chk("bp_new_and", last_out_a, 64'h0F00_0F00_0F00_0F00);

        // Reset after two RUN clocks discards the operation.
        send(2'b10, 64'h8000_0000_0000_0001, 64'h0000_0000_0000_0010);
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_out_valid", W'(out_valid), W'(0));
        chk("mid_rst_out", out, W'(0));
        chk("mid_rst_flags", W'({zf, sf, of_flag}), W'(0));
        @(negedge clk);
        chk("mid_rst_in_ready", W'(in_ready), W'(1));
        repeat (8) begin
            @(negedge clk);
            chk("mid_rst_no_stale", W'(out_valid), W'(0));
        end

        // Random transactions with random backpressure.
        for (int i = 0; i < 40; i++) begin
            a = {$urandom, $urandom};
            b = (i % 4 == 0) ? a : {$urandom, $urandom};
            out_ready = 1'($urandom_range(0, 1));
            send(2'($urandom_range(0, 3)), a, b);
            repeat ($urandom_range(0, 8)) @(posedge clk);
            #1;
            out_ready = 1'b1;
            wait_idle();
        end

        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("final_queue_a_empty", W'(qa.size()), W'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
